// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the data-RAM port arbiter: widths, FSM encoding,
// requester IDs and the default host starvation limit.
package dmem_port_arbiter_pkg;
    localparam int DMEMADDRW      = 10;
    localparam int DATA_W         = 32;
    localparam int STARVE_MAX_DEF = 8;

    typedef enum logic {
        S_CORE   = 1'b0,
        S_HBURST = 1'b1
    } state_t;

    localparam logic [1:0] REQ_CRD  = 2'd0;
    localparam logic [1:0] REQ_CWR  = 2'd1;
    localparam logic [1:0] REQ_HOST = 2'd2;
endpackage

// File: rtl/dmem_port_arbiter_burst_addr_gen.sv
// Host burst address generator: latches base and length on beat 0, then
// produces base+index (wrapping at 2^ADDR_W) and flags the final beat.
module dmem_burst_addr_gen
    import dmem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = DMEMADDRW,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [LEN_W-1:0]  len,
    input  logic              advance,
    output logic [ADDR_W-1:0] beat_addr,
    output logic [LEN_W-1:0]  beat_cnt,
    output logic              last
);
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] idx_q;
    logic [LEN_W-1:0]  cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            base_q <= '0;
            idx_q  <= '0;
            cnt_q  <= '0;
        end else if (start) begin
            // beat 0 is issued directly from the request, so the next beat is index 1
            base_q <= base;
            idx_q  <= ADDR_W'(1);
            cnt_q  <= len;
        end else if (advance) begin
            idx_q <= idx_q + ADDR_W'(1);
            cnt_q <= cnt_q - LEN_W'(1);
        end
    end

    assign beat_addr = base_q + idx_q;
    assign beat_cnt  = cnt_q;
    assign last      = (cnt_q == LEN_W'(1));
endmodule

// File: rtl/dmem_port_arbiter.sv
// Single-port data RAM arbiter: core read > core write > host, with a
// starvation counter that forces a host slot and burst locking for the host.
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = DMEMADDRW,
    parameter int DATA_W     = dmem_port_arbiter_pkg::DATA_W,
    parameter int LEN_W      = 4,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_rd_req,
    input  logic [ADDR_W-1:0] c_rd_addr,
    output logic              c_rd_gnt,
    output logic              c_rd_vld,
    output logic [DATA_W-1:0] c_rd_dat,
    input  logic              c_wr_req,
    input  logic [ADDR_W-1:0] c_wr_addr,
    input  logic [DATA_W-1:0] c_wr_dat,
    output logic              c_wr_gnt,
    input  logic              h_req,
    input  logic              h_we,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [LEN_W-1:0]  h_len,
    input  logic [DATA_W-1:0] h_wdat,
    output logic              h_gnt,
    output logic              h_rvld,
    output logic [DATA_W-1:0] h_rdat,
    output logic              h_done,
    output logic              core_stall,
    output logic              ram_cs_b,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdat,
    input  logic [DATA_W-1:0] ram_rdat,
    output logic              dbg_state
);
    localparam int SC_W = $clog2(STARVE_MAX + 1);

    // Handshake: a request is held with stable address/data until its grant;
    // the transfer happens in the grant cycle and read data returns one cycle later.
    state_t            state, next_state;
    logic [SC_W-1:0]   starve_cnt;
    logic              lat_we;
    logic              host_beat0;
    logic              ag_adv;
    logic [ADDR_W-1:0] ag_addr;
    logic [LEN_W-1:0]  beat_cnt;
    logic              ag_last;

    dmem_burst_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .start     (host_beat0),
        .base      (h_addr),
        .len       (h_len),
        .advance   (ag_adv),
        .beat_addr (ag_addr),
        .beat_cnt  (beat_cnt),
        .last      (ag_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_CORE;
            starve_cnt <= '0;
            lat_we     <= 1'b0;
            c_rd_vld   <= 1'b0;
            h_rvld     <= 1'b0;
        end else begin
            state    <= next_state;
            c_rd_vld <= c_rd_gnt;
            h_rvld   <= h_gnt & ~ram_we;
            if (host_beat0) begin
                lat_we     <= h_we;
                starve_cnt <= '0;
            end else if (h_req && !h_gnt && starve_cnt != SC_W'(STARVE_MAX)) begin
                starve_cnt <= starve_cnt + SC_W'(1);
            end
        end
    end

    always_comb begin
        next_state = state;
        host_beat0 = 1'b0;
        ag_adv     = 1'b0;
        c_rd_gnt   = 1'b0;
        c_wr_gnt   = 1'b0;
        h_gnt      = 1'b0;
        h_done     = 1'b0;
        core_stall = 1'b0;
        ram_cs_b   = 1'b1;
        ram_we     = 1'b0;
        ram_addr   = '0;
        ram_wdat   = '0;
        if (!rst) begin
            case (state)
                S_CORE: begin
                    if (h_req && starve_cnt == SC_W'(STARVE_MAX)) begin
                        host_beat0 = 1'b1;
                    end else if (c_rd_req) begin
                        c_rd_gnt = 1'b1;
                        ram_cs_b = 1'b0;
                        ram_addr = c_rd_addr;
                    end else if (c_wr_req) begin
                        c_wr_gnt = 1'b1;
                        ram_cs_b = 1'b0;
                        ram_we   = 1'b1;
                        ram_addr = c_wr_addr;
                        ram_wdat = c_wr_dat;
                    end else if (h_req) begin
                        host_beat0 = 1'b1;
                    end
                    if (host_beat0) begin
                        h_gnt    = 1'b1;
                        ram_cs_b = 1'b0;
                        ram_we   = h_we;
                        ram_addr = h_addr;
                        ram_wdat = h_wdat;
                        if (h_len == '0) h_done = 1'b1;
                        else             next_state = S_HBURST;
                    end
                end
                S_HBURST: begin
                    h_gnt    = 1'b1;
                    ag_adv   = 1'b1;
                    ram_cs_b = 1'b0;
                    ram_we   = lat_we;
                    ram_addr = ag_addr;
                    ram_wdat = h_wdat;
                    if (ag_last) begin
                        h_done     = 1'b1;
                        next_state = S_CORE;
                    end
                end
                default: next_state = S_CORE;
            endcase
            core_stall = (c_rd_req & ~c_rd_gnt) | (c_wr_req & ~c_wr_gnt);
        end
    end

    assign c_rd_dat  = ram_rdat;
    assign h_rdat    = ram_rdat;
    assign dbg_state = state;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a behavioural synchronous RAM.
module tb_dmem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        c_rd_req, c_wr_req, h_req, h_we;
    logic [9:0]  c_rd_addr, c_wr_addr, h_addr;
    logic [31:0] c_wr_dat, h_wdat;
    logic [3:0]  h_len;
    logic        c_rd_gnt, c_rd_vld, c_wr_gnt, h_gnt, h_rvld, h_done, core_stall;
    logic        ram_cs_b, ram_we, dbg_state;
    logic [31:0] c_rd_dat, h_rdat, ram_wdat, ram_rdat;
    logic [9:0]  ram_addr;
    logic [31:0] mem [0:1023];
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!ram_cs_b) begin
            if (ram_we) mem[ram_addr] <= ram_wdat;
            else        ram_rdat <= mem[ram_addr];
        end
    end

    dmem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .c_rd_req(c_rd_req), .c_rd_addr(c_rd_addr), .c_rd_gnt(c_rd_gnt),
        .c_rd_vld(c_rd_vld), .c_rd_dat(c_rd_dat),
        .c_wr_req(c_wr_req), .c_wr_addr(c_wr_addr), .c_wr_dat(c_wr_dat),
        .c_wr_gnt(c_wr_gnt),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_len(h_len),
        .h_wdat(h_wdat), .h_gnt(h_gnt), .h_rvld(h_rvld), .h_rdat(h_rdat),
        .h_done(h_done), .core_stall(core_stall),
        .ram_cs_b(ram_cs_b), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdat(ram_wdat), .ram_rdat(ram_rdat), .dbg_state(dbg_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change 1ns after the edge, checks follow 2ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'(i) ^ 32'h5A5A0000;
        mem[10'h012] = 32'hDEADBEEF;
        mem[10'h100] = 32'h11111111;
        mem[10'h101] = 32'h22222222;
        ram_rdat = '0;
        rst = 1'b1;
        c_rd_req = 0; c_wr_req = 0; h_req = 0; h_we = 0;
        c_rd_addr = '0; c_wr_addr = '0; h_addr = '0; h_len = '0;
        c_wr_dat = '0; h_wdat = '0;
        repeat (3) tick();
        rst = 1'b0;
        settle();
        chk("rst_cs_b", 32'(ram_cs_b), 1);
        chk("rst_grants", {c_rd_gnt, c_wr_gnt, h_gnt, h_done, core_stall}, 0);
        chk("rst_vld", {c_rd_vld, h_rvld, ram_we}, 0);
        chk("rst_bus", {ram_addr, ram_wdat[21:0]}, 0);
        chk("rst_state", 32'(dbg_state), 0);

        // core read only
        tick();
        c_rd_req = 1; c_rd_addr = 10'h012;
        settle();
        chk("crd_gnt", 32'(c_rd_gnt), 1);
        chk("crd_cs_b", 32'(ram_cs_b), 0);
        chk("crd_stall0", 32'(core_stall), 0);
        tick();
        c_rd_req = 0;
        settle();
        chk("crd_vld", 32'(c_rd_vld), 1);
        chk("crd_dat", c_rd_dat, 32'hDEADBEEF);
        chk("crd_stall1", 32'(core_stall), 0);

        // simultaneous core read and write
        tick();
        c_rd_req = 1; c_rd_addr = 10'h020;
        c_wr_req = 1; c_wr_addr = 10'h030; c_wr_dat = 32'h12345678;
        settle();
        chk("rw_rd_gnt", 32'(c_rd_gnt), 1);
        chk("rw_wr_gnt0", 32'(c_wr_gnt), 0);
        chk("rw_stall", 32'(core_stall), 1);
        tick();
        c_rd_req = 0;
        settle();
        chk("rw_wr_gnt1", 32'(c_wr_gnt), 1);
        chk("rw_we", 32'(ram_we), 1);
        chk("rw_addr", 32'(ram_addr), 32'h030);
        chk("rw_stall1", 32'(core_stall), 0);
        tick();
        c_wr_req = 0;
        settle();
        chk("rw_mem", mem[10'h030], 32'h12345678);

        // host write burst wrapping past the top of RAM
        tick();
        h_req = 1; h_we = 1; h_addr = 10'h3FE; h_len = 4'd3; h_wdat = 32'hA0A0A0A0;
        settle();
        chk("hw_b0_gnt", 32'(h_gnt), 1);
        chk("hw_b0_addr", 32'(ram_addr), 32'h3FE);
        chk("hw_b0_we", 32'(ram_we), 1);
        chk("hw_b0_done", 32'(h_done), 0);
        tick();
        h_req = 0; h_we = 0; h_wdat = 32'hA1A1A1A1;
        settle();
        chk("hw_b1_gnt", 32'(h_gnt), 1);
        chk("hw_b1_addr", 32'(ram_addr), 32'h3FF);
        chk("hw_b1_we", 32'(ram_we), 1);
        tick();
        h_wdat = 32'hA2A2A2A2; c_rd_req = 1; c_rd_addr = 10'h000;
        settle();
        chk("hw_b2_addr", 32'(ram_addr), 32'h000);
        chk("hw_b2_stall", {c_rd_gnt, core_stall, h_done}, 3'b010);
        tick();
        h_wdat = 32'hA3A3A3A3;
        settle();
        chk("hw_b3_addr", 32'(ram_addr), 32'h001);
        chk("hw_b3_done", {h_gnt, h_done, core_stall, c_rd_gnt}, 4'b1110);
        tick();
        settle();
        chk("hw_after", {c_rd_gnt, core_stall, h_gnt, h_done}, 4'b1000);
        tick();
        c_rd_req = 0;
        settle();
        chk("hw_rd_vld", 32'(c_rd_vld), 1);
        chk("hw_rd_dat", c_rd_dat, 32'hA2A2A2A2);
        chk("hw_mem_3fe", mem[10'h3FE], 32'hA0A0A0A0);
        chk("hw_mem_001", mem[10'h001], 32'hA3A3A3A3);

        // starvation: host wins on the 9th contested cycle
        tick();
        c_rd_req = 1; c_rd_addr = 10'h040;
        h_req = 1; h_we = 0; h_addr = 10'h050; h_len = 4'd0;
        settle();
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("starve_deny%0d", i), {c_rd_gnt, h_gnt}, 2'b10);
            tick();
            settle();
        end
        chk("starve_win", {h_gnt, h_done, c_rd_gnt, core_stall}, 4'b1101);
        chk("starve_addr", 32'(ram_addr), 32'h050);
        tick();
        settle();
        chk("starve_clr", {c_rd_gnt, h_gnt}, 2'b10);
        chk("starve_rvld", 32'(h_rvld), 1);
        chk("starve_rdat", h_rdat, 32'h5A5A0050);
        tick();
        c_rd_req = 0; h_req = 0;
        tick();

        // host read burst
        h_req = 1; h_we = 0; h_addr = 10'h100; h_len = 4'd1;
        settle();
        chk("hr_b0", {h_gnt, h_done, h_rvld, ram_we}, 4'b1000);
        tick();
        h_req = 0;
        settle();
        chk("hr_b1", {h_gnt, h_done, h_rvld}, 3'b111);
        chk("hr_b1_addr", 32'(ram_addr), 32'h101);
        chk("hr_dat0", h_rdat, 32'h11111111);
        tick();
        settle();
        chk("hr_rvld1", {h_rvld, h_gnt}, 2'b10);
        chk("hr_dat1", h_rdat, 32'h22222222);
        tick();
        settle();
        chk("hr_rvld_end", 32'(h_rvld), 0);

        // reset in the middle of a long burst
        tick();
        h_req = 1; h_we = 0; h_addr = 10'h200; h_len = 4'd7;
        settle();
        chk("rb_b0", 32'(h_gnt), 1);
        tick();
        h_req = 0;
        settle();
        chk("rb_b1", {h_gnt, dbg_state}, 2'b11);
        tick();
        rst = 1;
        settle();
        chk("rb_in_rst", {h_gnt, h_done, ram_cs_b}, 3'b001);
        tick();
        rst = 0;
        settle();
        chk("rb_grants", {c_rd_gnt, c_wr_gnt, h_gnt, h_done}, 0);
        chk("rb_cs_b", 32'(ram_cs_b), 1);
        chk("rb_state", 32'(dbg_state), 0);
        chk("rb_vld", {c_rd_vld, h_rvld}, 0);
        tick();
        settle();
        chk("rb_idle", {h_gnt, h_done, ram_cs_b, dbg_state}, 4'b0010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port data RAM between three requesters: core operand read (indirect @IDX fetch raised by the source decoder), core result writeback, and an external host loader that moves key/ciphertext blocks in bursts.
- Sits between the decoder/execute stage and the data RAM macro. It produces core_stall for the pipeline controller.
- Core has priority. A starvation counter guarantees the host a slot. Host bursts lock the port until they finish.

Parameters:
- ADDR_W, 10 (=`DMEMADDRW), data RAM address width
- DATA_W, 32, data RAM word width
- LEN_W, 4, host burst length field width; a burst is h_len+1 beats, so up to 16
- STARVE_MAX, 8, number of denied host cycles before the host is forced to win

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- c_rd_req  in  1  core indirect operand read request (inverse of decoder dat_ram_addr_en_b)
- c_rd_addr  in  ADDR_W  core read address
- c_rd_gnt  out  1  core read accepted this cycle
- c_rd_vld  out  1  c_rd_dat valid (one cycle after c_rd_gnt)
- c_rd_dat  out  DATA_W  core read data
- c_wr_req  in  1  core writeback request
- c_wr_addr  in  ADDR_W  core write address
- c_wr_dat  in  DATA_W  core write data
- c_wr_gnt  out  1  core write accepted this cycle
- h_req  in  1  host burst request
- h_we  in  1  host burst direction, 1 = write
- h_addr  in  ADDR_W  host burst base address
- h_len  in  LEN_W  host beats minus one
- h_wdat  in  DATA_W  host write data for the current beat
- h_gnt  out  1  host beat accepted this cycle
- h_rvld  out  1  h_rdat valid
- h_rdat  out  DATA_W  host read data
- h_done  out  1  one-cycle pulse on the last host beat
- core_stall  out  1  a core request is pending and was not granted
- ram_cs_b  out  1  RAM chip select, active low
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_wdat  out  DATA_W  RAM write data
- ram_rdat  in  DATA_W  RAM read data; synchronous, 1-cycle latency

Behaviour:
- Synchronous reset, active-high, single clock clk.
- Reset values:
  - state = S_CORE
  - starve_cnt = 0, beat_cnt = 0
  - c_rd_vld = 0, h_rvld = 0, h_done = 0
  - all grants = 0, core_stall = 0
  - ram_cs_b = 1, ram_we = 0, ram_addr = 0, ram_wdat = 0
- Grants and the ram_* bus are combinational from the current state and requests. The RAM samples them at the next edge.
- c_rd_vld and h_rvld are registered: they assert one cycle after the corresponding read grant. c_rd_dat and h_rdat both carry ram_rdat.
- At most one grant per cycle. When nothing is granted, ram_cs_b = 1.
- S_CORE, in priority order:
  1. If h_req and starve_cnt == STARVE_MAX: grant host beat 0. Latch h_we, h_addr and h_len. Set beat_cnt = h_len. Go to S_HBURST, or stay in S_CORE with h_done = 1 if h_len == 0.
  2. Else if c_rd_req: grant the core read.
  3. Else if c_wr_req: grant the core write.
  4. Else if h_req: host beat 0, same as rule 1.
- S_HBURST:
  - Every cycle is a host beat; h_gnt = 1 in each.
  - Beat address = base + beat index, modulo 2^ADDR_W, so it wraps past the top of RAM.
  - For writes, h_wdat is sampled in the grant cycle. ram_we = latched h_we.
  - beat_cnt decrements each beat. On the beat where beat_cnt == 1, h_done = 1 and the FSM returns to S_CORE.
  - Core requests are never granted in this state.
- Deasserting h_req mid-burst is ignored; the burst always completes.
- starve_cnt:
  - Increments, saturating at STARVE_MAX, in every cycle where h_req = 1 and h_gnt = 0.
  - Clears on any host beat-0 grant.
- core_stall = (c_rd_req & ~c_rd_gnt) | (c_wr_req & ~c_wr_gnt).
  - When a core read and a core write arrive in the same cycle, the read wins and core_stall = 1.
- A reset mid-burst aborts the burst: no h_done, and in-flight c_rd_vld/h_rvld are cleared.
- Core requesters must hold their request and address stable until granted.

Decomposition:
- Shared package holds: DMEMADDRW and DATA_W, the state encoding (S_CORE, S_HBURST), requester IDs (REQ_CRD = 0, REQ_CWR = 1, REQ_HOST = 2), and the STARVE_MAX default.
- One natural sub-module, dmem_burst_addr_gen. It contains the base/beat counter, performs the wrapping address add, and generates last-beat detection.

Test Plan:
- Core read only: c_rd_req = 1 with addr 0x012, RAM[0x012] = 0xDEADBEEF.
  - Cycle 0: c_rd_gnt = 1, ram_cs_b = 0.
  - Cycle 1: c_rd_vld = 1 with c_rd_dat = 0xDEADBEEF. core_stall stays 0.
- Core read and write in the same cycle:
  - Cycle 0: read granted, core_stall = 1.
  - Cycle 1: write granted, with ram_we = 1 and ram_addr = c_wr_addr.
- Host write burst: h_req, h_we = 1, h_addr = 0x3FE, h_len = 3, with core idle.
  - Four consecutive h_gnt at addresses 0x3FE, 0x3FF, 0x000, 0x001.
  - h_done on the 4th beat. A c_rd_req raised in beat 2 is stalled until the cycle after h_done.
- Starvation: c_rd_req held continuously while h_req = 1 and h_len = 0.
  - Host is denied for 8 cycles, then h_gnt in cycle 8 with core_stall = 1 that cycle.
  - starve_cnt returns to 0.
- Host read burst: h_len = 1 at 0x100.
  - h_rvld high for two cycles, delayed one cycle from the grants, with data RAM[0x100] then RAM[0x101].
- Reset mid-burst: rst asserted at beat 2 of an h_len = 7 burst.
  - Next cycle: all grants 0, ram_cs_b = 1, no h_done, state S_CORE.
